// File: rtl/addsub_if.sv
// Operand/result bundle for the sequential adder/subtractor: request side
// (operands + op) and response side (result + flags), each with valid/ready.
interface addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;
    logic             negative;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow, zero, negative
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit slice per cycle,
// carry rippled between slices through a register, flags latched on the last slice.
module addsub_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic    clk,
    input  logic    reset,
    addsub_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             negative_q, negative_d;

    logic [CHUNK-1:0] a_slice [N];
    logic [CHUNK-1:0] b_slice [N];
    logic [CHUNK-1:0] cur_a;
    logic [CHUNK-1:0] cur_b;
    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] result_run;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign a_slice[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_slice[gi] = b_q[gi*CHUNK +: CHUNK];
            // Only the slice being processed this cycle takes the new sum.
            assign result_run[gi*CHUNK +: CHUNK] =
                (count_q == CW'(gi)) ? slice_sum[CHUNK-1:0] : result_q[gi*CHUNK +: CHUNK];
        end

        if (N == 1) begin : g_single
            assign cur_a = a_slice[0];
            assign cur_b = b_slice[0];
        end else begin : g_multi
            assign cur_a = a_slice[count_q];
            assign cur_b = b_slice[count_q];
        end
    endgenerate

    assign slice_sum = {1'b0, cur_a} + {1'b0, cur_b} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        count_d    = count_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        negative_d = negative_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d = result_run;
                carry_d  = slice_sum[CHUNK];
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    // a^b^sum at the MSB recovers the carry into the MSB.
                    cout_d     = slice_sum[CHUNK];
                    overflow_d = cur_a[CHUNK-1] ^ cur_b[CHUNK-1] ^ slice_sum[CHUNK-1]
                                 ^ slice_sum[CHUNK];
                    zero_d     = (result_run == '0);
                    negative_d = slice_sum[CHUNK-1];
                    count_d    = '0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            count_q    <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            count_q    <= count_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: a 32/8 instance (directed corners, backpressure, reset
// mid-op, random ops) and an 8/8 instance (single-cycle, random back-to-back).
module tb_addsub_seq;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    addsub_if #(.WIDTH(32)) bus32 ();
    addsub_if #(.WIDTH(8))  bus8 ();

    addsub_seq #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    addsub_seq #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {cout, overflow, zero, negative, result} from plain integer arithmetic.
    function automatic logic [35:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint     sr;
        logic [63:0] wide;
        logic [31:0] r;
        logic        c;
        logic        ovf;
        sr   = s ? (longint'($signed(a)) - longint'($signed(b)))
                 : (longint'($signed(a)) + longint'($signed(b)));
        r    = s ? (a - b) : (a + b);
        wide = {32'b0, a} + {32'b0, b};
        c    = s ? (a >= b) : wide[32];
        ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {c, ovf, (r == 32'd0), r[31], r};
    endfunction

    function automatic logic [11:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int         sr;
        logic [7:0] r;
        logic       c;
        logic       ovf;
        sr  = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        r   = s ? (a - b) : (a + b);
        c   = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
        ovf = (sr > 127) || (sr < -128);
        return {c, ovf, (r == 8'd0), r[7], r};
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input logic [35:0] exp);
        int n;
        n = 0;
        while (!bus32.in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("rdy32", bus32.in_ready, 1);
        bus32.in_valid = 1'b1;
        bus32.a = a;
        bus32.b = b;
        bus32.sub = s;
        @(posedge clk); #1;
        bus32.a = $urandom;
        bus32.b = $urandom;
        bus32.sub = 1'($urandom_range(0, 1));
        n = 0;
        while (!bus32.out_valid && n < 64) begin
            bus32.in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        bus32.in_valid = 1'b0;
        check("lat32", n, 4);
        check("res32", bus32.result, exp[31:0]);
        check("cout32", bus32.cout, exp[35]);
        check("ovf32", bus32.overflow, exp[34]);
        check("zero32", bus32.zero, exp[33]);
        check("neg32", bus32.negative, exp[32]);
        for (int i = 0; i < hold; i++) begin
            bus32.in_valid = 1'($urandom_range(0, 1));
            bus32.a = $urandom;
            @(posedge clk); #1;
            check("hold32_ov", bus32.out_valid, 1);
            check("hold32_ir", bus32.in_ready, 0);
            check("hold32_res", {bus32.cout, bus32.overflow, bus32.zero, bus32.negative, bus32.result}, exp);
        end
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        @(posedge clk); #1;
        bus32.out_ready = 1'b0;
        check("idle32", {bus32.in_ready, bus32.out_valid}, 2'b10);
        $display("op32 a=%08h b=%08h sub=%0d hold=%0d -> res=%08h c=%0d v=%0d z=%0d n=%0d",
                 a, b, s, hold, exp[31:0], exp[35], exp[34], exp[33], exp[32]);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [11:0] exp);
        int n;
        n = 0;
        while (!bus8.in_ready && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("rdy8", bus8.in_ready, 1);
        bus8.in_valid = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.sub = s;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom);
        n = 0;
        while (!bus8.out_valid && n < 64) begin
            @(posedge clk); #1; n++;
        end
        check("lat8", n, 1);
        check("res8", {bus8.cout, bus8.overflow, bus8.zero, bus8.negative, bus8.result}, exp);
        $display("op8 a=%02h b=%02h sub=%0d -> res=%02h c=%0d v=%0d z=%0d n=%0d",
                 a, b, s, exp[7:0], exp[11], exp[10], exp[9], exp[8]);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          hold;
        logic [35:0] exp;   // {cout, ovf, zero, neg, result}
    } vec_t;

    vec_t dir [6];

    initial begin
        dir[0] = '{32'd5,        32'd3, 1'b1, 0, {4'b1000, 32'd2}};
        dir[1] = '{32'd3,        32'd5, 1'b1, 0, {4'b0001, 32'hFFFF_FFFE}};
        dir[2] = '{32'd7,        32'd7, 1'b1, 1, {4'b1010, 32'd0}};
        dir[3] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 0, {4'b0101, 32'h8000_0000}};
        dir[4] = '{32'h8000_0000, 32'd1, 1'b1, 2, {4'b1100, 32'h7FFF_FFFF}};
        dir[5] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 5, {4'b1010, 32'd0}};

        reset = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst32_hs", {bus32.in_ready, bus32.out_valid}, 2'b10);
        check("rst32_data", {bus32.cout, bus32.overflow, bus32.zero, bus32.negative, bus32.result}, 36'd0);
        check("rst8_hs", {bus8.in_ready, bus8.out_valid}, 2'b10);
        check("rst8_data", {bus8.cout, bus8.overflow, bus8.zero, bus8.negative, bus8.result}, 12'd0);
        reset = 1'b0;

        foreach (dir[i]) run32(dir[i].a, dir[i].b, dir[i].s, dir[i].hold, dir[i].exp);

        // Abort an add while slice 2 is being processed.
        bus32.in_valid = 1'b1;
        bus32.a = 32'h1234_5678;
        bus32.b = 32'h1111_1111;
        bus32.sub = 1'b0;
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstrun_hs", {bus32.in_ready, bus32.out_valid}, 2'b10);
        check("rstrun_data", {bus32.cout, bus32.overflow, bus32.zero, bus32.negative, bus32.result}, 36'd0);
        $display("op32 reset during slice 2");
        run32(32'd10, 32'd4, 1'b1, 0, {4'b1000, 32'd6});

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            rs = 1'($urandom_range(0, 1));
            run32(ra, rb, rs, int'($urandom_range(0, 2)), ref32(ra, rb, rs));
        end

        run8(8'h80, 8'h01, 1'b1, {4'b1100, 8'h7F});
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic       rs;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            run8(ra, rb, rs, ref8(ra, rb, rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
